btb_predictor: RTL and testbench
================================

# btb_predictor

Branch target buffer that answers fetch-stage lookups and absorbs the update writes issued by `branch_unit`. It supplies `PcMatchValid` and `CtrlIn` one stage after fetch, plus a combinational predicted target for next-PC selection. It is updated from `WriteEnable`/`CtrlOut` and flushed by `FlushPipePC`. The block is a direct-mapped table with a register stage and an invalidate sweep engine.

## Interface
- `PC_W`, 32: PC width.
- `IDX_W`, 4: index bits; `DEPTH` = 2**IDX_W entries.
- `OFFS_W`, 2: byte-offset bits ignored in index/tag (word-aligned instructions).
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `FetchPC` in PC_W: PC being fetched this cycle.
- `Stall` in 1: hold the lookup register stage.
- `Flush` in 1: driven by `FlushPipePC`; clears the lookup register stage.
- `PredHit` out 1: combinational; valid entry with matching tag for `FetchPC`.
- `PredTaken` out 1: combinational; `PredHit & ctr[1]`.
- `PredTarget` out PC_W: combinational; stored target on hit, 0 on miss.
- `PcMatchValid` out 1: registered `PredHit`.
- `CtrlIn` out 2: registered counter of the hit entry, 2'b00 on miss.
- `UpdWe` in 1: driven by `WriteEnable`; write request.
- `UpdPC` in PC_W: PC of the resolving branch/jump.
- `UpdTarget` in PC_W: resolved target.
- `UpdCtrl` in 2: driven by `CtrlOut`; new 2-bit counter value.
- `InvReq` in 1: start a full-table invalidate.
- `InvBusy` out 1: high while the sweep runs.

## Operation
- Entry layout: valid, tag = PC[PC_W-1:IDX_W+OFFS_W], target[PC_W], ctr[2].
- Index = PC[IDX_W+OFFS_W-1:OFFS_W].
- Lookup: `PredHit` = valid[idx] & tag match. During CLEAR, `PredHit` is forced to 0.
- Write: on a rising edge with `UpdWe` & state IDLE, the entry at `UpdPC` index is written with valid=1, tag, `UpdTarget` and `UpdCtrl`. Any previous occupant is replaced; no associativity.
- `UpdWe` with `UpdCtrl` unchanged still rewrites the target.
- Register stage: unless `Stall`, capture `PredHit` into `PcMatchValid` and `ctr` (or 00 on miss) into `CtrlIn`.
  - `Flush` overrides `Stall` and loads 0/00.
- Invalidate FSM has two states.
  - IDLE: `InvReq` moves to CLEAR with sweep pointer = 0.
  - CLEAR: each cycle clears valid[ptr] and increments ptr. After clearing entry DEPTH-1, go to IDLE. The pointer wraps to 0.
- `InvReq` while in CLEAR is ignored (no restart).
- `InvReq` and `UpdWe` in the same IDLE cycle: invalidate wins and the write is dropped.
- Writes arriving during CLEAR are dropped. The branch unit re-learns the entry on its next resolution.
- Counter semantics belong to `branch_unit`; this block stores `UpdCtrl` verbatim and interprets only bit 1 (taken).

## Timing
- Reset (async, any state including mid-sweep):
  - All valid bits = 0; FSM = IDLE; ptr = 0.
  - `PcMatchValid` = 0; `CtrlIn` = 00; `InvBusy` = 0.
  - Targets and counters are not reset.
- Lookup latency: `Pred*` has 0 cycles (same cycle as `FetchPC`). `PcMatchValid`/`CtrlIn` have 1 cycle.
- Write visibility: a lookup in the cycle after the write edge sees the new entry.
- Invalidate: `InvBusy` rises the edge after `InvReq` and stays high exactly DEPTH cycles. The first lookup that can hit again is the cycle `InvBusy` falls.
- Same-index write and lookup in one cycle: the lookup returns old contents (unless bypass enabled).

## Configuration
- `BTB_WRITE_BYPASS_EN` defined: when `UpdWe` is accepted and `UpdPC` index/tag equal `FetchPC` index/tag, the lookup outputs use `UpdTarget`/`UpdCtrl` with hit=1 in the same cycle. The registered outputs follow the bypassed value.
- Undefined: no forwarding; the lookup sees table contents only.

## Structure
- Shared package `btb_pkg`:
  - FSM state typedef (`BTB_IDLE`, `BTB_CLEAR`).
  - Entry struct typedef.
  - Counter constants (`CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11), shared with `branch_unit`.
- One sub-module: `btb_inv_fsm` (sweep state, pointer, `InvBusy`, per-entry clear strobe). Table, lookup and register stage stay in the top.

## Test plan
- After reset, `FetchPC`=0x100 → `PredHit`=0; next cycle `PcMatchValid`=0, `CtrlIn`=00.
- Write `UpdPC`=0x104, `UpdTarget`=0x200, `UpdCtrl`=10, then `FetchPC`=0x104 next cycle → `PredHit`=1, `PredTaken`=1, `PredTarget`=0x200; following cycle `PcMatchValid`=1, `CtrlIn`=10.
- Alias: after the previous write, write `UpdPC`=0x144 (same index, DEPTH=16) → lookup 0x104 misses and 0x144 hits.
- `InvReq` pulse with 3 valid entries → `InvBusy` high 16 cycles; `UpdWe` during the sweep is dropped; all lookups miss afterwards.
- `Stall`=1 with a changing `FetchPC` → `PcMatchValid`/`CtrlIn` hold. `Flush`=1 with `Stall`=1 → registers clear to 0/00.
- Same-cycle write+lookup of 0x108: with `BTB_WRITE_BYPASS_EN` → hit, target = `UpdTarget`; without → miss.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB types: sweep FSM states, table entry layout and the 2-bit counter
// encodings that branch_unit also uses.
package btb_pkg;

    localparam int BTB_PC_W   = 32;
    localparam int BTB_IDX_W  = 4;
    localparam int BTB_OFFS_W = 2;
    localparam int BTB_TAG_W  = BTB_PC_W - BTB_IDX_W - BTB_OFFS_W;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_CLEAR = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-1:0]  target;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/btb_inv_fsm.sv
// Full-table invalidate sweep: one entry cleared per cycle, busy for exactly
// 2**IDX_W cycles. Requests arriving mid-sweep are ignored.
module btb_inv_fsm
    import btb_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inv_req_i,
    output logic             busy_o,
    output logic             clr_o,
    output logic [IDX_W-1:0] clr_idx_o
);

    btb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BTB_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                BTB_IDLE: begin
                    if (inv_req_i) begin
                        state_q <= BTB_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                BTB_CLEAR: begin
                    // Pointer wraps back to 0 on the final entry.
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == {IDX_W{1'b1}}) begin
                        state_q <= BTB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= BTB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign clr_o     = busy_q;
    assign clr_idx_o = ptr_q;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with combinational lookup, one register
// stage and an invalidate sweep. Optional same-cycle write forwarding: BTB_WRITE_BYPASS_EN.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int PC_W   = BTB_PC_W,
    parameter int IDX_W  = BTB_IDX_W,
    parameter int OFFS_W = BTB_OFFS_W
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [PC_W-1:0] FetchPC,
    input  logic            Stall,
    input  logic            Flush,
    output logic            PredHit,
    output logic            PredTaken,
    output logic [PC_W-1:0] PredTarget,
    output logic            PcMatchValid,
    output logic [1:0]      CtrlIn,
    input  logic            UpdWe,
    input  logic [PC_W-1:0] UpdPC,
    input  logic [PC_W-1:0] UpdTarget,
    input  logic [1:0]      UpdCtrl,
    input  logic            InvReq,
    output logic            InvBusy
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - OFFS_W;

    btb_entry_t       tbl_q [DEPTH];
    logic [IDX_W-1:0] f_idx, u_idx, clr_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             clr, wr_acc;
    btb_entry_t       rd_e;
    logic             hit;
    logic [PC_W-1:0]  tgt;
    logic [1:0]       ctr;
    logic             pmv_q, pmv_d;
    logic [1:0]       cin_q, cin_d;

    assign f_idx = FetchPC[IDX_W+OFFS_W-1:OFFS_W];
    assign f_tag = FetchPC[PC_W-1:IDX_W+OFFS_W];
    assign u_idx = UpdPC[IDX_W+OFFS_W-1:OFFS_W];
    assign u_tag = UpdPC[PC_W-1:IDX_W+OFFS_W];

    btb_inv_fsm #(.IDX_W(IDX_W)) u_inv (
        .clk_i     (CLK),
        .rst_ni    (nRST),
        .inv_req_i (InvReq),
        .busy_o    (InvBusy),
        .clr_o     (clr),
        .clr_idx_o (clr_idx)
    );

    // An invalidate request in the same cycle takes priority over the write.
    assign wr_acc = UpdWe & ~InvBusy & ~InvReq;
    assign rd_e   = tbl_q[f_idx];

    always_comb begin
        hit = rd_e.valid & (rd_e.tag == f_tag) & ~InvBusy;
        tgt = rd_e.target;
        ctr = rd_e.ctr;
`ifdef BTB_WRITE_BYPASS_EN
        if (wr_acc && (u_idx == f_idx) && (u_tag == f_tag)) begin
            hit = 1'b1;
            tgt = UpdTarget;
            ctr = UpdCtrl;
        end
`endif
    end

    assign PredHit    = hit;
    assign PredTaken  = hit & ctr[1];
    assign PredTarget = hit ? tgt : '0;

    always_comb begin
        pmv_d = pmv_q;
        cin_d = cin_q;
        if (Flush) begin
            pmv_d = 1'b0;
            cin_d = CTR_SNT;
        end else if (!Stall) begin
            pmv_d = hit;
            cin_d = hit ? ctr : CTR_SNT;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pmv_q <= 1'b0;
            cin_q <= CTR_SNT;
        end else begin
            pmv_q <= pmv_d;
            cin_q <= cin_d;
        end
    end

    assign PcMatchValid = pmv_q;
    assign CtrlIn       = cin_q;

    // Only valid bits are reset; target/ctr payload is left as-is.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i].valid <= 1'b0;
        end else begin
            if (clr) tbl_q[clr_idx].valid <= 1'b0;
            if (wr_acc) tbl_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: UpdTarget, ctr: UpdCtrl};
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: vector table for lookup/write/stall/flush,
// plus sequences for the invalidate sweep and async reset.
module tb_btb_predictor;

`ifdef BTB_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK, nRST;
    logic [31:0] FetchPC, UpdPC, UpdTarget, PredTarget;
    logic        Stall, Flush, PredHit, PredTaken, PcMatchValid, UpdWe, InvReq, InvBusy;
    logic [1:0]  CtrlIn, UpdCtrl;

    btb_predictor dut (
        .CLK(CLK), .nRST(nRST), .FetchPC(FetchPC), .Stall(Stall), .Flush(Flush),
        .PredHit(PredHit), .PredTaken(PredTaken), .PredTarget(PredTarget),
        .PcMatchValid(PcMatchValid), .CtrlIn(CtrlIn), .UpdWe(UpdWe), .UpdPC(UpdPC),
        .UpdTarget(UpdTarget), .UpdCtrl(UpdCtrl), .InvReq(InvReq), .InvBusy(InvBusy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] fpc;
        logic        we;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [1:0]  uctl;
        logic        stall;
        logic        flush;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        pmv;
        logic [1:0]  cin;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];
    int   n_chk, n_fail;

    function automatic vec_t mk(input logic [31:0] fpc, input logic we, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic [1:0] uctl, input logic stall,
                                input logic flush, input logic hit, input logic taken,
                                input logic [31:0] tgt, input logic pmv, input logic [1:0] cin);
        vec_t v;
        v.fpc = fpc; v.we = we; v.upc = upc; v.utgt = utgt; v.uctl = uctl;
        v.stall = stall; v.flush = flush; v.hit = hit; v.taken = taken;
        v.tgt = tgt; v.pmv = pmv; v.cin = cin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n, bad_hit;
        logic [31:0] miss_pcs [6];
        n_chk = 0; n_fail = 0;

        //       fpc     we  upc     utgt    uc     st fl  hit  taken tgt                   pmv  cin
        vt[0]  = mk(32'h100, 0, 0,       0,       2'b00, 0, 0, 0,   0,   0,                    0,   2'b00);
        vt[1]  = mk(32'h100, 1, 32'h104, 32'h200, 2'b10, 0, 0, 0,   0,   0,                    0,   2'b00);
        vt[2]  = mk(32'h104, 0, 0,       0,       2'b00, 0, 0, 1,   1,   32'h200,              0,   2'b00);
        vt[3]  = mk(32'h104, 0, 0,       0,       2'b00, 0, 0, 1,   1,   32'h200,              1,   2'b10);
        vt[4]  = mk(32'h144, 1, 32'h144, 32'h300, 2'b01, 0, 0, BYP, 0,   BYP ? 32'h300 : 32'h0, 1,   2'b10);
        vt[5]  = mk(32'h104, 0, 0,       0,       2'b00, 0, 0, 0,   0,   0,                    BYP, BYP ? 2'b01 : 2'b00);
        vt[6]  = mk(32'h144, 0, 0,       0,       2'b00, 0, 0, 1,   0,   32'h300,              0,   2'b00);
        vt[7]  = mk(32'h144, 1, 32'h144, 32'h340, 2'b01, 0, 0, 1,   0,   BYP ? 32'h340 : 32'h300, 1, 2'b01);
        vt[8]  = mk(32'h144, 0, 0,       0,       2'b00, 0, 0, 1,   0,   32'h340,              1,   2'b01);
        vt[9]  = mk(32'h108, 1, 32'h108, 32'h400, 2'b11, 0, 0, BYP, BYP, BYP ? 32'h400 : 32'h0, 1,   2'b01);
        vt[10] = mk(32'h108, 0, 0,       0,       2'b00, 0, 0, 1,   1,   32'h400,              BYP, BYP ? 2'b11 : 2'b00);
        vt[11] = mk(32'h144, 0, 0,       0,       2'b00, 1, 0, 1,   0,   32'h340,              1,   2'b11);
        vt[12] = mk(32'h100, 0, 0,       0,       2'b00, 1, 0, 0,   0,   0,                    1,   2'b11);
        vt[13] = mk(32'h104, 0, 0,       0,       2'b00, 1, 1, 0,   0,   0,                    1,   2'b11);
        vt[14] = mk(32'h108, 0, 0,       0,       2'b00, 0, 0, 1,   1,   32'h400,              0,   2'b00);
        vt[15] = mk(32'h108, 1, 32'h110, 32'h500, 2'b10, 0, 0, 1,   1,   32'h400,              1,   2'b11);

        nRST = 1'b0; FetchPC = 0; Stall = 0; Flush = 0; UpdWe = 0; UpdPC = 0;
        UpdTarget = 0; UpdCtrl = 0; InvReq = 0;
        #12;
        chk("rst_pmv", PcMatchValid, 0);
        chk("rst_cin", CtrlIn, 0);
        chk("rst_busy", InvBusy, 0);
        #5 nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge CLK); #1;
            FetchPC = vt[i].fpc; UpdWe = vt[i].we; UpdPC = vt[i].upc;
            UpdTarget = vt[i].utgt; UpdCtrl = vt[i].uctl;
            Stall = vt[i].stall; Flush = vt[i].flush;
            @(negedge CLK);
            chk($sformatf("v%0d.hit", i),   PredHit,      vt[i].hit);
            chk($sformatf("v%0d.taken", i), PredTaken,    vt[i].taken);
            chk($sformatf("v%0d.tgt", i),   PredTarget,   vt[i].tgt);
            chk($sformatf("v%0d.pmv", i),   PcMatchValid, vt[i].pmv);
            chk($sformatf("v%0d.cin", i),   CtrlIn,       vt[i].cin);
        end

        // Invalidate request colliding with a write: the write must be dropped.
        @(posedge CLK); #1;
        Stall = 0; Flush = 0; FetchPC = 32'h108;
        UpdWe = 1; UpdPC = 32'h118; UpdTarget = 32'h600; UpdCtrl = 2'b10; InvReq = 1;
        @(negedge CLK);
        chk("inv_busy_pre", InvBusy, 0);
        chk("inv_idle_hit", PredHit, 1);
        @(posedge CLK); #1;
        InvReq = 0; UpdPC = 32'h11C;
        busy_n = 0; bad_hit = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (!InvBusy) break;
            busy_n++;
            if (PredHit) bad_hit++;
            @(posedge CLK); #1;
            InvReq = (busy_n == 5);
        end
        UpdWe = 0; InvReq = 0;
        chk("inv_busy_len", busy_n, 16);
        chk("inv_hit_during", bad_hit, 0);

        miss_pcs = '{32'h104, 32'h144, 32'h108, 32'h110, 32'h118, 32'h11C};
        @(posedge CLK); #1;
        for (int j = 0; j < 6; j++) begin
            FetchPC = miss_pcs[j]; #1;
            chk($sformatf("post_inv_miss_%0h", miss_pcs[j]), PredHit, 0);
        end

        // Write after the sweep is visible on the next cycle.
        @(posedge CLK); #1;
        UpdWe = 1; UpdPC = 32'h104; UpdTarget = 32'h700; UpdCtrl = 2'b11; FetchPC = 32'h200;
        @(posedge CLK); #1;
        UpdWe = 0; FetchPC = 32'h104; #1;
        chk("post_inv_wr_hit", PredHit, 1);
        chk("post_inv_wr_tgt", PredTarget, 32'h700);

        // Async reset clears valid bits and the register stage.
        @(posedge CLK); #2;
        nRST = 0; #1;
        chk("arst_hit", PredHit, 0);
        chk("arst_pmv", PcMatchValid, 0);
        chk("arst_cin", CtrlIn, 0);
        #3 nRST = 1;

        // Reset in the middle of a sweep returns the FSM to idle.
        @(posedge CLK); #1; InvReq = 1;
        @(posedge CLK); #1; InvReq = 0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("mid_sweep_busy", InvBusy, 1);
        #1 nRST = 0;
        #1 chk("mid_sweep_rst_busy", InvBusy, 0);
        #1 nRST = 1;
        @(posedge CLK); #1;
        UpdWe = 1; UpdPC = 32'h13C; UpdTarget = 32'h800; UpdCtrl = 2'b01; FetchPC = 32'h100;
        @(posedge CLK); #1;
        UpdWe = 0; FetchPC = 32'h13C; #1;
        chk("after_rst_wr_hit", PredHit, 1);
        chk("after_rst_wr_taken", PredTaken, 0);
        chk("after_rst_wr_tgt", PredTarget, 32'h800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
